// File: rtl/mask_window_sequencer.sv
// Mask-unit initiator: steps a WIN_W window across a latched SEG_W segment, issues one mask
// request per position and forwards each result downstream. MSEQ_TIMEOUT_EN adds a WAIT timeout.
module mask_window_sequencer #(
  parameter int unsigned SEG_W   = 61,
  parameter int unsigned WIN_W   = 15,
  parameter int unsigned POS_W   = 7,
  parameter int unsigned STEP    = 15,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seg_valid_i,
  output logic             seg_ready_o,
  input  logic [SEG_W-1:0] seg_data_i,
  output logic             mask_en_o,
  output logic [WIN_W-1:0] mask_in_o,
  output logic [POS_W-1:0] mask_pos_o,
  input  logic             mask_done_i,
  input  logic [WIN_W-1:0] mask_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIN_W-1:0] res_data_o,
  output logic [POS_W-1:0] res_pos_o,
  output logic             res_last_o,
  output logic             busy_o,
  output logic             timeout_err_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  if (STEP == 0 || STEP > WIN_W || TIMEOUT == 0) begin : g_param_check
    $error("mask_window_sequencer: STEP must be 1..WIN_W and TIMEOUT nonzero");
  end

  logic [1:0]             state_q, state_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [WIN_W-1:0]       mask_in_q, mask_in_d;
  logic [WIN_W-1:0]       res_data_q, res_data_d;
  logic [POS_W-1:0]       res_pos_q, res_pos_d;
  logic                   res_last_q, res_last_d;
  logic [POS_W:0]         pos_next;
  logic                   last_win;
  logic [SEG_W+WIN_W-1:0] seg_ext;
  logic                   timeout_hit;

  // One extra bit so pos+STEP past the segment end does not wrap in the compare.
  assign pos_next = {1'b0, pos_q} + (POS_W+1)'(STEP);
  assign last_win = (pos_next >= (POS_W+1)'(SEG_W));

  // Zero padding above the segment supplies the out-of-range window bits.
  assign seg_ext   = {{WIN_W{1'b0}}, seg_d};
  assign mask_in_d = (state_d == StIssue) ? WIN_W'(seg_ext >> pos_d) : mask_in_q;

`ifdef MSEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign timeout_hit = (state_q == StWait) && !mask_done_i && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == StWait && !mask_done_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err_o = err_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    pos_d      = pos_q;
    res_data_d = res_data_q;
    res_pos_d  = res_pos_q;
    res_last_d = res_last_q;
    unique case (state_q)
      StIdle: begin
        if (seg_valid_i) begin
          seg_d   = seg_data_i;
          pos_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mask_done_i) begin
          res_data_d = mask_out_i;
          res_pos_d  = pos_q;
          res_last_d = last_win;
          state_d    = StOut;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StOut: begin
        if (res_ready_i) begin
          pos_d   = pos_next[POS_W-1:0];
          state_d = res_last_q ? StIdle : StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      seg_q      <= '0;
      pos_q      <= '0;
      mask_in_q  <= '0;
      res_data_q <= '0;
      res_pos_q  <= '0;
      res_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      pos_q      <= pos_d;
      mask_in_q  <= mask_in_d;
      res_data_q <= res_data_d;
      res_pos_q  <= res_pos_d;
      res_last_q <= res_last_d;
    end
  end

  assign seg_ready_o = (state_q == StIdle);
  assign mask_en_o   = (state_q == StIssue);
  assign mask_in_o   = mask_in_q;
  assign mask_pos_o  = pos_q;
  assign res_valid_o = (state_q == StOut);
  assign res_data_o  = res_data_q;
  assign res_pos_o   = res_pos_q;
  assign res_last_o  = res_last_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mask_window_sequencer.sv
// Bench for mask_window_sequencer: directed vector table, hand-written corner sequences and a
// randomized run scored against a window-list reference model.
module tb_mask_window_sequencer;

  localparam int SEG_W   = 61;
  localparam int WIN_W   = 15;
  localparam int POS_W   = 7;
  localparam int STEP    = 15;
  localparam int TIMEOUT = 16;
  localparam int NSEG    = 150;

  localparam logic [SEG_W-1:0] SEG_ONES = '1;
  localparam logic [SEG_W-1:0] SEG_B47  = SEG_W'(1) << 47;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             seg_valid = 1'b0;
  logic             seg_ready;
  logic [SEG_W-1:0] seg_data = '0;
  logic             mask_en;
  logic [WIN_W-1:0] mask_in;
  logic [POS_W-1:0] mask_pos;
  logic             mask_done = 1'b0;
  logic [WIN_W-1:0] mask_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIN_W-1:0] res_data;
  logic [POS_W-1:0] res_pos;
  logic             res_last;
  logic             busy;
  logic             timeout_err;

  mask_window_sequencer #(
    .SEG_W  (SEG_W),
    .WIN_W  (WIN_W),
    .POS_W  (POS_W),
    .STEP   (STEP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_valid_i  (seg_valid),
    .seg_ready_o  (seg_ready),
    .seg_data_i   (seg_data),
    .mask_en_o    (mask_en),
    .mask_in_o    (mask_in),
    .mask_pos_o   (mask_pos),
    .mask_done_i  (mask_done),
    .mask_out_i   (mask_out),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_pos_o    (res_pos),
    .res_last_o   (res_last),
    .busy_o       (busy),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  // Stand-in mask unit result: any fixed mixing of window and position.
  function automatic logic [WIN_W-1:0] mfun(input logic [WIN_W-1:0] w, input logic [POS_W-1:0] p);
    logic [WIN_W-1:0] pe;
    pe = WIN_W'(p);
    return w ^ (pe << 3) ^ 15'h2A5A;
  endfunction

  function automatic logic [WIN_W-1:0] win_ref(input logic [SEG_W-1:0] s, input int p);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int k = 0; k < WIN_W; k++) if (p + k < SEG_W) w[k] = s[p+k];
    return w;
  endfunction

  // Mask unit model: answers resp_delay cycles after mask_en, garbage on mask_out otherwise.
  int               resp_on = 1;
  int               resp_delay = 1;
  logic             pend = 1'b0;
  int               pend_cnt = 0;
  logic [WIN_W-1:0] pend_data = '0;

  always @(posedge clk) begin
    mask_done <= 1'b0;
    mask_out  <= WIN_W'($urandom);
    if (rst) begin
      pend <= 1'b0;
    end else if (mask_en && resp_on != 0) begin
      if (resp_delay <= 1) begin
        mask_done <= 1'b1;
        mask_out  <= mfun(mask_in, mask_pos);
        pend      <= 1'b0;
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= resp_delay - 1;
        pend_data <= mfun(mask_in, mask_pos);
      end
    end else if (pend) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) begin
        mask_done <= 1'b1;
        mask_out  <= pend_data;
        pend      <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [POS_W-1:0] pos;
    logic [WIN_W-1:0] win;
  } req_t;
  typedef struct {
    logic [WIN_W-1:0] data;
    logic [POS_W-1:0] pos;
    logic             last;
  } res_t;

  req_t             exp_req[$];
  res_t             exp_res[$];
  req_t             re;
  res_t             rr;
  logic [POS_W-1:0] log_pos[$];
  logic [WIN_W-1:0] log_in[$];
  logic [WIN_W-1:0] log_rdata[$];
  logic [POS_W-1:0] log_rpos[$];
  logic             log_rlast[$];
  int unsigned      log_rcyc[$];
  logic             chk_en = 1'b0;
  int               seg_acc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mask_en) begin
        log_pos.push_back(mask_pos);
        log_in.push_back(mask_in);
      end
      if (res_valid && res_ready) begin
        log_rdata.push_back(res_data);
        log_rpos.push_back(res_pos);
        log_rlast.push_back(res_last);
        log_rcyc.push_back(cyc);
      end
      if (chk_en) begin
        if (seg_valid && seg_ready) begin
          seg_acc++;
          for (int p = 0; p < SEG_W; p += STEP) begin
            re.pos  = POS_W'(p);
            re.win  = win_ref(seg_data, p);
            rr.data = mfun(re.win, re.pos);
            rr.pos  = re.pos;
            rr.last = (p + STEP >= SEG_W);
            exp_req.push_back(re);
            exp_res.push_back(rr);
          end
        end
        if (mask_en) begin
          if (exp_req.size() == 0) fail("rnd_unexpected_mask_en");
          else begin
            re = exp_req.pop_front();
            check("rnd_mask_pos", mask_pos, re.pos);
            check("rnd_mask_in", mask_in, re.win);
          end
        end
        if (res_valid && res_ready) begin
          if (exp_res.size() == 0) fail("rnd_unexpected_result");
          else begin
            rr = exp_res.pop_front();
            check("rnd_res_data", res_data, rr.data);
            check("rnd_res_pos", res_pos, rr.pos);
            check("rnd_res_last", res_last, rr.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_pos.delete();
    log_in.delete();
    log_rdata.delete();
    log_rpos.delete();
    log_rlast.delete();
    log_rcyc.delete();
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    if (busy) fail(name);
  endtask

  task automatic wait_res(input string name, input int lim);
    int n = 0;
    while (!res_valid && n < lim) begin
      tick();
      n++;
    end
    if (!res_valid) fail(name);
  endtask

  task automatic run_seg(input logic [SEG_W-1:0] s);
    clear_logs();
    resp_on    = 1;
    resp_delay = 1;
    res_ready  = 1'b1;
    seg_data   = s;
    seg_valid  = 1'b1;
    tick();
    seg_valid = 1'b0;
    wait_idle("run_seg_idle", 100);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [SEG_W-1:0] seg;
    int               idx;
    logic [POS_W-1:0] pos;
    logic [WIN_W-1:0] win;
    logic             last;
  } vec_t;

  vec_t             tbl[10];
  logic [SEG_W-1:0] s3;
  logic [SEG_W-1:0] sb;
  logic [WIN_W-1:0] d0;
  logic [POS_W-1:0] p0;
  logic             l0;
  logic             stable;
  logic             en_seen;
  logic             got_last;
  int               bad_ready;
  logic             late_valid;

  initial begin
    tbl[0] = '{SEG_ONES, 0, 7'd0,  15'h7FFF, 1'b0};
    tbl[1] = '{SEG_ONES, 1, 7'd15, 15'h7FFF, 1'b0};
    tbl[2] = '{SEG_ONES, 2, 7'd30, 15'h7FFF, 1'b0};
    tbl[3] = '{SEG_ONES, 3, 7'd45, 15'h7FFF, 1'b0};
    tbl[4] = '{SEG_ONES, 4, 7'd60, 15'h0001, 1'b1};
    tbl[5] = '{SEG_B47,  0, 7'd0,  15'h0000, 1'b0};
    tbl[6] = '{SEG_B47,  1, 7'd15, 15'h0000, 1'b0};
    tbl[7] = '{SEG_B47,  2, 7'd30, 15'h0000, 1'b0};
    tbl[8] = '{SEG_B47,  3, 7'd45, 15'h0004, 1'b0};
    tbl[9] = '{SEG_B47,  4, 7'd60, 15'h0000, 1'b1};

    do_reset();
    check("rst_seg_ready", seg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mask_en", mask_en, 0);
    check("rst_mask_in", mask_in, 0);
    check("rst_mask_pos", mask_pos, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_pos", res_pos, 0);
    check("rst_res_last", res_last, 0);
    check("rst_timeout_err", timeout_err, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].idx == 0) begin
        run_seg(tbl[i].seg);
        check($sformatf("tbl%0d_req_count", i), log_pos.size(), 5);
        check($sformatf("tbl%0d_res_count", i), log_rpos.size(), 5);
        if (i == 0) begin
          for (int j = 0; j + 1 < log_rcyc.size(); j++)
            check($sformatf("cadence_%0d", j), log_rcyc[j+1] - log_rcyc[j], 3);
        end
      end
      if (log_pos.size() > tbl[i].idx) begin
        check($sformatf("tbl%0d_mask_pos", i), log_pos[tbl[i].idx], tbl[i].pos);
        check($sformatf("tbl%0d_mask_in", i), log_in[tbl[i].idx], tbl[i].win);
      end else fail($sformatf("tbl%0d_mask_req", i));
      if (log_rpos.size() > tbl[i].idx) begin
        check($sformatf("tbl%0d_res_pos", i), log_rpos[tbl[i].idx], tbl[i].pos);
        check($sformatf("tbl%0d_res_last", i), log_rlast[tbl[i].idx], tbl[i].last);
        check($sformatf("tbl%0d_res_data", i), log_rdata[tbl[i].idx],
              mfun(tbl[i].win, tbl[i].pos));
      end else fail($sformatf("tbl%0d_result", i));
    end

    // Backpressure on the second result.
    s3         = 61'h0ABC_DEF0_1234_5678;
    resp_on    = 1;
    resp_delay = 1;
    res_ready  = 1'b0;
    seg_data   = s3;
    seg_valid  = 1'b1;
    tick();
    seg_valid = 1'b0;
    wait_res("bp_res1", 20);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_res("bp_res2", 20);
    d0      = res_data;
    p0      = res_pos;
    l0      = res_last;
    stable  = 1'b1;
    en_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== d0 || res_pos !== p0 || res_last !== l0)
        stable = 1'b0;
      if (mask_en) en_seen = 1'b1;
    end
    check("bp_hold_stable", stable, 1);
    check("bp_no_mask_en", en_seen, 0);
    check("bp_res_pos", p0, 15);
    check("bp_res_data", d0, mfun(win_ref(s3, 15), 15));
    res_ready = 1'b1;
    tick();
    check("bp_issue_after_accept", mask_en, 1);
    check("bp_next_pos", mask_pos, 30);
    wait_idle("bp_idle", 100);

    // seg_valid held through a whole segment: next one taken right after the last handshake.
    sb        = 61'h1555_0F0F_3C3C_A5A5;
    bad_ready = 0;
    got_last  = 1'b0;
    res_ready = 1'b1;
    seg_data  = SEG_ONES;
    seg_valid = 1'b1;
    tick();
    seg_data = sb;
    for (int i = 0; i < 40 && !got_last; i++) begin
      @(negedge clk);
      if (seg_ready) bad_ready++;
      if (res_valid && res_last) got_last = 1'b1;
    end
    if (!got_last) fail("hold_last_result");
    check("hold_seg_ready_low_while_busy", bad_ready, 0);
    @(negedge clk);
    check("hold_seg_ready_after_last", seg_ready, 1);
    tick();
    seg_valid = 1'b0;
    check("hold_second_accepted", busy, 1);
    check("hold_second_mask_en", mask_en, 1);
    check("hold_second_mask_in", mask_in, win_ref(sb, 0));
    wait_idle("hold_idle", 100);

    // Reset while waiting for mask_done.
    resp_on   = 0;
    seg_data  = SEG_ONES;
    seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
    tick();
    check("rstw_in_wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_res_valid", res_valid, 0);
    check("rstw_mask_en", mask_en, 0);
    check("rstw_seg_ready", seg_ready, 1);
    check("rstw_busy", busy, 0);
    resp_on    = 1;
    late_valid = 1'b0;
    repeat (5) begin
      tick();
      if (res_valid) late_valid = 1'b1;
    end
    check("rstw_no_partial_result", late_valid, 0);

    // mask_done never arrives.
    resp_on   = 0;
    seg_data  = SEG_ONES;
    seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
    repeat (11) tick();
    check("to_early_busy", busy, 1);
    check("to_early_err", timeout_err, 0);
    repeat (10) tick();
`ifdef MSEQ_TIMEOUT_EN
    check("to_err_set", timeout_err, 1);
    check("to_back_idle", busy, 0);
    check("to_no_result", res_valid, 0);
    repeat (3) tick();
    check("to_err_sticky", timeout_err, 1);
`else
    check("to_still_busy", busy, 1);
    check("to_err_tied", timeout_err, 0);
    check("to_no_result", res_valid, 0);
`endif
    resp_on = 1;
    do_reset();
    check("to_err_cleared", timeout_err, 0);

    // Randomized traffic against the reference window list.
    clear_logs();
    exp_req.delete();
    exp_res.delete();
    seg_acc = 0;
    chk_en  = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      seg_valid  = (seg_acc < NSEG) && ($urandom_range(0, 3) != 0);
      seg_data   = SEG_W'({$urandom(), $urandom()});
      res_ready  = ($urandom_range(0, 2) != 0);
      resp_delay = $urandom_range(1, 4);
      tick();
      if (seg_acc >= NSEG && !busy && exp_res.size() == 0) break;
    end
    seg_valid = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    check("rnd_segments_accepted", seg_acc, NSEG);
    check("rnd_req_drained", exp_req.size(), 0);
    check("rnd_res_drained", exp_res.size(), 0);
    check("rnd_idle_at_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
